// File: rtl/execute_muldiv.sv
// Execute stage: operand select, single-cycle ALU, iterative multiply/divide,
// and the execute/memory pipeline register.
module execute_muldiv #(
  parameter int WIDTH          = 32,
  parameter int REG_SIZE       = 5,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                validE,
  input  logic [WIDTH-1:0]    rdata1E,
  input  logic [WIDTH-1:0]    rdata2E,
  input  logic [WIDTH-1:0]    immE,
  input  logic [WIDTH-1:0]    pcE,
  input  logic [REG_SIZE-1:0] writeRegE,
  input  logic [3:0]          ALUControlE,
  input  logic [1:0]          ALUSrcE,
  input  logic                regWriteE,
  input  logic                memWriteE,
  input  logic                mem2regE,
  input  logic                flushE,
  input  logic                stallM,
  output logic                stallE,
  output logic                validM,
  output logic [WIDTH-1:0]    writeDataM,
  output logic [WIDTH-1:0]    ALUResultM,
  output logic [WIDTH-1:0]    pcM,
  output logic [REG_SIZE-1:0] writeRegM,
  output logic                zeroM,
  output logic                regWriteM,
  output logic                memWriteM,
  output logic                mem2regM
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] src1, src2, aluResult, mulDivResult, resultE;
  logic [SW-1:0]    shamt;
  logic             isMulDivE, signedDivE, negAE, negBE, start;
  logic [WIDTH-1:0] magA, magB;

  logic [3:0]       opReg;
  logic [WIDTH-1:0] hiReg, loReg, opnReg, dividendReg;
  logic [WIDTH-1:0] hiNext, loNext, quot, remv;
  logic [WIDTH:0]   sum, trial;
  logic             qbit, negQ, negR, divZero, divOvf;
  logic [CW-1:0]    count;

  always_comb begin
    src1 = rdata1E;
    src2 = immE;
    case (ALUSrcE)
      2'b00:   begin src1 = rdata1E; src2 = immE;       end
      2'b01:   begin src1 = rdata1E; src2 = rdata2E;    end
      2'b10:   begin src1 = pcE;     src2 = WIDTH'(4);  end
      default: begin src1 = pcE;     src2 = immE;       end
    endcase
  end

  assign shamt = src2[SW-1:0];

  always_comb begin
    aluResult = '0;
    case (ALUControlE)
      4'd0:    aluResult = src1 + src2;
      4'd1:    aluResult = src1 - src2;
      4'd2:    aluResult = {{(WIDTH-1){1'b0}}, $signed(src1) < $signed(src2)};
      4'd3:    aluResult = {{(WIDTH-1){1'b0}}, src1 < src2};
      4'd4:    aluResult = src1 & src2;
      4'd5:    aluResult = src1 | src2;
      4'd6:    aluResult = src1 ^ src2;
      4'd7:    aluResult = src1 << shamt;
      4'd8:    aluResult = src1 >> shamt;
      4'd9:    aluResult = $unsigned($signed(src1) >>> shamt);
      default: aluResult = '0;
    endcase
  end

  // Signed divide works on magnitudes; signs are re-applied on the way out.
  assign isMulDivE  = (ALUControlE >= 4'd10);
  assign signedDivE = (ALUControlE == 4'd12) || (ALUControlE == 4'd14);
  assign negAE      = signedDivE & src1[WIDTH-1];
  assign negBE      = signedDivE & src2[WIDTH-1];
  assign magA       = negAE ? -src1 : src1;
  assign magB       = negBE ? -src2 : src2;
  assign start      = (state == IDLE) && validE && isMulDivE && !flushE;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = BUSY;
      BUSY:    if (flushE) stateNext = IDLE;
               else if (count == '0) stateNext = DONE;
      DONE:    if (flushE || !stallM) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign stallE = ((state == IDLE) && validE && isMulDivE) || (state == BUSY)
                || ((state == DONE) && stallM);

  always_ff @(posedge clk) begin
    if (start) begin
      opReg       <= ALUControlE;
      hiReg       <= '0;
      loReg       <= (ALUControlE >= 4'd12) ? magA : src1;
      opnReg      <= (ALUControlE >= 4'd12) ? magB : src2;
      dividendReg <= src1;
      negQ        <= negAE ^ negBE;
      negR        <= negAE;
      divZero     <= (src2 == '0);
      divOvf      <= signedDivE && (src1 == MOST_NEG) && (src2 == '1);
      count       <= CW'(N - 1);
    end else if (state == BUSY) begin
      hiReg <= hiNext;
      loReg <= loNext;
      count <= count - CW'(1);
    end
  end

  // One iteration = BITS_PER_CYCLE single-bit shift-add or restoring steps.
  always_comb begin
    hiNext = hiReg;
    loNext = loReg;
    sum    = '0;
    trial  = '0;
    qbit   = 1'b0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (opReg < 4'd12) begin
        sum    = {1'b0, hiNext} + (loNext[0] ? {1'b0, opnReg} : '0);
        loNext = {sum[0], loNext[WIDTH-1:1]};
        hiNext = sum[WIDTH:1];
      end else begin
        trial = {hiNext, loNext[WIDTH-1]};
        if (trial >= {1'b0, opnReg}) begin
          trial = trial - {1'b0, opnReg};
          qbit  = 1'b1;
        end else begin
          qbit  = 1'b0;
        end
        hiNext = trial[WIDTH-1:0];
        loNext = {loNext[WIDTH-2:0], qbit};
      end
    end
  end

  assign quot = negQ ? -loReg : loReg;
  assign remv = negR ? -hiReg : hiReg;

  always_comb begin
    mulDivResult = '0;
    case (opReg)
      4'd10:        mulDivResult = loReg;
      4'd11:        mulDivResult = hiReg;
      4'd12, 4'd13: mulDivResult = divZero ? '1 : (divOvf ? MOST_NEG : quot);
      4'd14, 4'd15: mulDivResult = divZero ? dividendReg : (divOvf ? '0 : remv);
      default:      mulDivResult = '0;
    endcase
  end

  assign resultE = (state == DONE) ? mulDivResult : aluResult;

  always_ff @(posedge clk) begin
    if (!reset) begin
      validM     <= 1'b0;
      writeDataM <= '0;
      ALUResultM <= '0;
      pcM        <= '0;
      writeRegM  <= '0;
      zeroM      <= 1'b0;
      regWriteM  <= 1'b0;
      memWriteM  <= 1'b0;
      mem2regM   <= 1'b0;
    end else if (!stallM) begin
      if (flushE || stallE) begin
        validM    <= 1'b0;
        regWriteM <= 1'b0;
        memWriteM <= 1'b0;
      end else begin
        validM     <= validE;
        writeDataM <= rdata2E;
        ALUResultM <= resultE;
        pcM        <= pcE;
        writeRegM  <= writeRegE;
        zeroM      <= (resultE == '0);
        regWriteM  <= regWriteE;
        memWriteM  <= memWriteE;
        mem2regM   <= mem2regE;
      end
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: a 1-bit-per-cycle instance plus a
// 4-bit-per-cycle instance sharing the same stimulus.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        validE;
  logic [31:0] rdata1E, rdata2E, immE, pcE;
  logic [4:0]  writeRegE;
  logic [3:0]  ALUControlE;
  logic [1:0]  ALUSrcE;
  logic        regWriteE, memWriteE, mem2regE, flushE, stallM;

  logic        stallE, validM, zeroM, regWriteM, memWriteM, mem2regM;
  logic [31:0] writeDataM, ALUResultM, pcM;
  logic [4:0]  writeRegM;

  logic        stallE4, validM4, zeroM4, regWriteM4, memWriteM4, mem2regM4;
  logic [31:0] writeDataM4, ALUResultM4, pcM4;
  logic [4:0]  writeRegM4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_muldiv #(.WIDTH(32), .REG_SIZE(5), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .validE(validE),
    .rdata1E(rdata1E), .rdata2E(rdata2E), .immE(immE), .pcE(pcE),
    .writeRegE(writeRegE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .regWriteE(regWriteE), .memWriteE(memWriteE), .mem2regE(mem2regE),
    .flushE(flushE), .stallM(stallM), .stallE(stallE), .validM(validM),
    .writeDataM(writeDataM), .ALUResultM(ALUResultM), .pcM(pcM),
    .writeRegM(writeRegM), .zeroM(zeroM), .regWriteM(regWriteM),
    .memWriteM(memWriteM), .mem2regM(mem2regM)
  );

  execute_muldiv #(.WIDTH(32), .REG_SIZE(5), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .validE(validE),
    .rdata1E(rdata1E), .rdata2E(rdata2E), .immE(immE), .pcE(pcE),
    .writeRegE(writeRegE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .regWriteE(regWriteE), .memWriteE(memWriteE), .mem2regE(mem2regE),
    .flushE(flushE), .stallM(stallM), .stallE(stallE4), .validM(validM4),
    .writeDataM(writeDataM4), .ALUResultM(ALUResultM4), .pcM(pcM4),
    .writeRegM(writeRegM4), .zeroM(zeroM4), .regWriteM(regWriteM4),
    .memWriteM(memWriteM4), .mem2regM(mem2regM4)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] src,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [31:0] pc);
    validE      = 1'b1;
    ALUControlE = op;
    ALUSrcE     = src;
    rdata1E     = a;
    rdata2E     = b;
    immE        = imm;
    pcE         = pc;
    writeRegE   = 5'(op + 4'd1);
    regWriteE   = 1'b1;
    memWriteE   = 1'b0;
    mem2regE    = 1'b0;
    flushE      = 1'b0;
  endtask

  task automatic runAlu(input string tag, input logic [3:0] op, input logic [1:0] src,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [31:0] exp);
    applyStimulus(op, src, a, b, imm, pc);
    nextCycle();
    checkOutput({tag, " result"}, ALUResultM, exp);
    checkOutput({tag, " zero"}, zeroM, exp == 32'd0);
    checkOutput({tag, " valid"}, validM, 1'b1);
  endtask

  // Expects 34-cycle latency and 33 stall cycles for the 1-bit instance.
  task automatic runMulDiv(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input bit checkFast);
    int cycles = 0;
    int stallCnt = 0;
    bit got = 0;
    applyStimulus(op, 2'b01, a, b, 32'd0, 32'h200);
    #1;
    while (!got && cycles < 200) begin
      if (stallE) stallCnt++;
      nextCycle();
      cycles++;
      if (checkFast && cycles == 10) begin
        checkOutput({tag, " b4 valid"}, validM4, 1'b1);
        checkOutput({tag, " b4 result"}, ALUResultM4, exp);
      end
      if (validM) got = 1;
    end
    checkOutput({tag, " latency"}, cycles, 34);
    checkOutput({tag, " stall cycles"}, stallCnt, 33);
    checkOutput({tag, " result"}, ALUResultM, exp);
    validE = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    stallM = 1'b0;
    applyStimulus(4'd0, 2'b00, 32'd5, 32'h1234, 32'd3, 32'h40);
    nextCycle();
    nextCycle();
    checkOutput("reset validM", validM, 1'b0);
    checkOutput("reset result", ALUResultM, 32'd0);
    checkOutput("reset writeData", writeDataM, 32'd0);
    checkOutput("reset pc", pcM, 32'd0);
    checkOutput("reset ctrl", {writeRegM, zeroM, regWriteM, memWriteM, mem2regM}, 9'd0);
    checkOutput("reset stallE", stallE, 1'b0);

    $display("[TB] single-cycle ops");
    reset = 1'b1;
    runAlu("add", 4'd0, 2'b00, 32'd5, 32'h1234, 32'd3, 32'h40, 32'd8);
    checkOutput("add writeData", writeDataM, 32'h1234);
    checkOutput("add pc", pcM, 32'h40);
    checkOutput("add writeReg", writeRegM, 5'd1);
    checkOutput("add regWrite", regWriteM, 1'b1);
    runAlu("sub", 4'd1, 2'b01, 32'd10, 32'd3, 32'd0, 32'h0, 32'd7);
    runAlu("slt", 4'd2, 2'b01, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0, 32'd1);
    runAlu("sltu", 4'd3, 2'b01, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0, 32'd0);
    runAlu("and", 4'd4, 2'b00, 32'hF0F0F0F0, 32'd0, 32'h0FF00FF0, 32'h0, 32'h00F000F0);
    runAlu("or", 4'd5, 2'b01, 32'hF0F0F0F0, 32'h0F0F0000, 32'd0, 32'h0, 32'hFFFFF0F0);
    runAlu("xor", 4'd6, 2'b01, 32'hFFFF0000, 32'h0F0F0F0F, 32'd0, 32'h0, 32'hF0F00F0F);
    runAlu("sll", 4'd7, 2'b00, 32'd1, 32'd0, 32'h3F, 32'h0, 32'h80000000);
    runAlu("srl", 4'd8, 2'b01, 32'h80000000, 32'd4, 32'd0, 32'h0, 32'h08000000);
    runAlu("sra", 4'd9, 2'b01, 32'h80000000, 32'd4, 32'd0, 32'h0, 32'hF8000000);
    runAlu("pc+4", 4'd0, 2'b10, 32'h999, 32'd0, 32'd0, 32'h100, 32'h104);
    runAlu("pc+imm", 4'd0, 2'b11, 32'h999, 32'd0, 32'h20, 32'h100, 32'h120);

    $display("[TB] multi-cycle ops");
    runMulDiv("mul 7x6", 4'd10, 32'd7, 32'd6, 32'd42, 1'b1);
    runMulDiv("div -7/2", 4'd12, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
    runMulDiv("rem -7/2", 4'd14, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
    runMulDiv("divu 9/0", 4'd13, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b0);
    runMulDiv("remu 9/0", 4'd15, 32'd9, 32'd0, 32'd9, 1'b0);
    runMulDiv("rem ovf", 4'd14, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0);
    runMulDiv("div ovf", 4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    runMulDiv("mulhu max", 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    runMulDiv("mul -3x5", 4'd10, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0);
    runMulDiv("divu 100/7", 4'd13, 32'd100, 32'd7, 32'd14, 1'b0);

    $display("[TB] flush in BUSY");
    applyStimulus(4'd12, 2'b01, 32'd100, 32'd7, 32'd0, 32'h300);
    for (int i = 0; i < 10; i++) nextCycle();
    flushE = 1'b1;
    nextCycle();
    checkOutput("flush validM", validM, 1'b0);
    applyStimulus(4'd1, 2'b01, 32'd3, 32'd3, 32'd0, 32'h304);
    #1;
    checkOutput("post-flush stallE", stallE, 1'b0);
    nextCycle();
    checkOutput("sub 3-3 result", ALUResultM, 32'd0);
    checkOutput("sub 3-3 zero", zeroM, 1'b1);
    checkOutput("sub 3-3 valid", validM, 1'b1);

    $display("[TB] stallM during DONE");
    applyStimulus(4'd15, 2'b01, 32'd100, 32'd7, 32'd0, 32'h400);
    for (int i = 0; i < 33; i++) nextCycle();
    stallM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stallM stallE", stallE, 1'b1);
      nextCycle();
      checkOutput("stallM held validM", validM, 1'b0);
    end
    stallM = 1'b0;
    #1;
    checkOutput("stallM release stallE", stallE, 1'b0);
    nextCycle();
    checkOutput("stallM release valid", validM, 1'b1);
    checkOutput("stallM release result", ALUResultM, 32'd2);
    stallM = 1'b1;
    applyStimulus(4'd0, 2'b00, 32'd1, 32'd0, 32'd1, 32'h404);
    nextCycle();
    checkOutput("stallM hold result", ALUResultM, 32'd2);
    checkOutput("stallM hold pc", pcM, 32'h400);
    stallM = 1'b0;
    nextCycle();
    checkOutput("after hold result", ALUResultM, 32'd2 - 32'd0);

    $display("[TB] reset mid-BUSY");
    applyStimulus(4'd12, 2'b01, 32'hFFFFFFF9, 32'd2, 32'd0, 32'h500);
    for (int i = 0; i < 5; i++) nextCycle();
    reset  = 1'b0;
    validE = 1'b0;
    nextCycle();
    checkOutput("midreset stallE", stallE, 1'b0);
    checkOutput("midreset validM", validM, 1'b0);
    reset = 1'b1;
    runMulDiv("mul after reset", 4'd10, 32'd1000, 32'd1000, 32'd1000000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_muldiv.md
# execute_muldiv

Parametrised execute stage for the pipelined core: selects ALU operands, runs single-cycle integer ops and iterative multiply/divide ops, and registers the result into the execute/memory pipeline register. It sits between decode and memory. For multi-cycle ops it stalls upstream, and it honours a downstream hold and an execute-stage flush.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits (even, ≥8)
- REG_SIZE, 5, register-index width
- BITS_PER_CYCLE, 1, mul/div bits retired per iteration (1, 2 or 4; must divide WIDTH)

Ports (clock and reset first):
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- validE  in  1  execute-stage op present
- rdata1E, rdata2E, immE, pcE  in  WIDTH  operands, immediate, PC
- writeRegE  in  REG_SIZE  destination register
- ALUControlE  in  4  operation select
- ALUSrcE  in  2  operand select
- regWriteE, memWriteE, mem2regE  in  1  sideband controls
- flushE  in  1  kill the op in execute
- stallM  in  1  memory stage cannot accept; M register holds
- stallE  out  1  upstream must hold all E inputs constant
- validM  out  1  M register holds a live op
- writeDataM, ALUResultM, pcM  out  WIDTH  registered rdata2E, result, PC
- writeRegM  out  REG_SIZE; zeroM, regWriteM, memWriteM, mem2regM  out  1

## Operation
- ALUSrcE operand pairs (src1, src2):
  - 00: rs1, imm
  - 01: rs1, rs2
  - 10: pc, 4
  - 11: pc, imm
- ALUControlE, single-cycle ops: 0 ADD, 1 SUB, 2 SLT (signed), 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA.
  - Shift amount is src2[$clog2(WIDTH)-1:0].
- ALUControlE, multi-cycle ops: 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- All arithmetic is modulo 2^WIDTH.
- zeroM = (ALUResult == 0).
- writeDataM = rdata2E, regardless of ALUSrcE.
- Multiplier: iterative shift-add on a 2·WIDTH-bit product.
- Divider: restoring division on magnitudes.
  - Signed quotient sign = sign(a) XOR sign(b).
  - Signed remainder takes the sign of the dividend.
- Divide special cases (result overridden; latency unchanged):
  - divide by zero: quotient all-ones; remainder = dividend.
  - signed overflow (most-negative ÷ −1): quotient = most-negative; remainder 0.
- FSM states IDLE, BUSY, DONE.
  - IDLE → BUSY: validE & multi-cycle op & !flushE. Operands are latched and the iteration counter is set to N−1, where N = WIDTH/BITS_PER_CYCLE.
  - BUSY: decrement the counter each cycle; at 0 go to DONE.
  - DONE → IDLE: when !stallM; the result loads into the M register.
- stallE = (IDLE & validE & multi-cycle op) | BUSY | (DONE & stallM).
- M register update, every edge, in priority order:
  - !reset: all M outputs 0 and FSM to IDLE.
  - stallM: hold all M outputs.
  - flushE, or stallE asserted: load a bubble (validM=0, regWriteM=0, memWriteM=0; other fields don't-care).
  - otherwise: load the E op, or the mul/div result in DONE; validM = validE.
- flushE in BUSY or DONE: FSM to IDLE next edge; the result is discarded and is never written to M.

## Timing
- Single-cycle op presented in cycle t with !stallM: result in M outputs in cycle t+1.
- Multi-cycle op presented in cycle t: the FSM is in BUSY for cycles t+1..t+N and in DONE at t+N+1.
  - With no stallM, validM is 1 in cycle t+N+2.
  - WIDTH=32, BITS_PER_CYCLE=1: latency 34 cycles, stallE high for 33.
- Each cycle of stallM during DONE adds one cycle of latency; the result is preserved.
- Reset mid-operation (BUSY or DONE): next cycle has FSM IDLE, validM=0, stallE=0 (unless a new multi-cycle op is presented).
- A multi-cycle op back-to-back with its predecessor is accepted in the cycle DONE exits; there is no idle gap beyond the IDLE acceptance cycle.

## Test plan
- Reset low for 2 cycles → all M outputs 0, stallE=0; release, then ADD rs1=5, imm=3, ALUSrc=00 → ALUResultM=8, zeroM=0, validM=1 next cycle.
- MUL 7×6 (ALUSrc=01), WIDTH=32, B=1 → stallE high for 33 cycles; ALUResultM=42 in cycle t+34. Repeat with B=4 → result in cycle t+10.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 9/0 → 0xFFFFFFFF; REM 0x80000000/−1 → 0; DIV 0x80000000/−1 → 0x80000000.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; flushE asserted in BUSY cycle 10 → no validM for that op; a following SUB 3−3 → ALUResultM=0, zeroM=1 one cycle later.
- stallM held for 3 cycles during DONE → M outputs frozen, stallE high; result appears on release. Reset pulsed mid-BUSY → FSM IDLE, validM=0.
